cv_pad_port: RTL and testbench

CV_PAD_PORT -- requirements
Module: cv_pad_port

---
 rtl/cv_pad_pkg.sv | 48 ++++
 rtl/cv_spinner.sv | 102 ++++++++++
 rtl/cv_pad_port.sv | 98 +++++++++
 tb/tb_cv_pad_port.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cv_pad_pkg.sv
// Shared definitions for the ColecoVision controller port: joystick bitmap
// indices, keypad matrix codes and the spinner pulse-state enum.
package cv_pad_pkg;

    localparam int JOY_R      = 0;
    localparam int JOY_L      = 1;
    localparam int JOY_D      = 2;
    localparam int JOY_U      = 3;
    localparam int JOY_FIRE1  = 4;
    localparam int JOY_FIRE2  = 5;
    localparam int JOY_STAR   = 6;
    localparam int JOY_HASH   = 7;
    localparam int JOY_KEY0   = 8;
    localparam int JOY_PURPLE = 18;
    localparam int JOY_BLUE   = 19;

    // Matrix codes as {p1,p2,p3,p4}; digit codes indexed by key number
    localparam logic [9:0][3:0] KEY_DIGIT = {
        4'b1011, 4'b1000, 4'b1100, 4'b0111, 4'b1001,
        4'b0001, 4'b0110, 4'b1101, 4'b1110, 4'b0011
    };
    localparam logic [3:0] KEY_STAR   = 4'b1010;
    localparam logic [3:0] KEY_HASH   = 4'b0101;
    localparam logic [3:0] KEY_PURPLE = 4'b0100;
    localparam logic [3:0] KEY_BLUE   = 4'b0010;
    localparam logic [3:0] KEY_NONE   = 4'b1111;

    typedef enum logic [1:0] {
        SPIN_IDLE,
        SPIN_PULSE,
        SPIN_GAP
    } spin_state_t;

    // Lowest priority is written first so higher-priority keys overwrite it
    function automatic logic [3:0] key_encode(input logic [31:0] joy);
        logic [3:0] code;
        code = KEY_NONE;
        if (joy[JOY_BLUE])   code = KEY_BLUE;
        if (joy[JOY_PURPLE]) code = KEY_PURPLE;
        if (joy[JOY_HASH])   code = KEY_HASH;
        if (joy[JOY_STAR])   code = KEY_STAR;
        for (int i = 9; i >= 0; i--) begin
            if (joy[JOY_KEY0 + i]) code = KEY_DIGIT[i];
        end
        return code;
    endfunction

endpackage

// File: rtl/cv_spinner.sv
// One spinner channel: saturating signed accumulator drained one count per
// pulse on p7, with the pulse direction reported on p9.
module cv_spinner
    import cv_pad_pkg::*;
#(
    parameter int SPIN_W    = 8,
    parameter int PULSE_LEN = 4
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     ce_i,
    input  logic signed [SPIN_W-1:0] spin_d_i,
    input  logic                     spin_stb_i,
    output logic                     ctrl_p7_o,
    output logic                     ctrl_p9_o
);

    localparam int CNT_W = (PULSE_LEN > 1) ? $clog2(PULSE_LEN) : 1;
    localparam logic [CNT_W-1:0]        CNT_LAST = CNT_W'(PULSE_LEN - 1);
    localparam logic signed [SPIN_W+1:0] SAT_MAX = (SPIN_W+2)'((2 ** (SPIN_W - 1)) - 1);
    localparam logic signed [SPIN_W+1:0] SAT_MIN = -SAT_MAX;
    localparam logic signed [SPIN_W+1:0] ONE     = (SPIN_W+2)'(1);

    function automatic logic signed [SPIN_W-1:0] sat_acc(input logic signed [SPIN_W+1:0] v);
        if (v > SAT_MAX) return SAT_MAX[SPIN_W-1:0];
        if (v < SAT_MIN) return SAT_MIN[SPIN_W-1:0];
        return v[SPIN_W-1:0];
    endfunction

    spin_state_t              state, state_nxt;
    logic [CNT_W-1:0]         cnt, cnt_nxt;
    logic signed [SPIN_W-1:0] acc, acc_nxt;
    logic signed [SPIN_W+1:0] sum, dec, delta;
    logic                     step, p7_nxt, p9_nxt;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        p7_nxt    = ctrl_p7_o;
        p9_nxt    = ctrl_p9_o;
        step      = 1'b0;
        unique case (state)
            SPIN_IDLE: begin
                if (acc != '0) begin
                    step      = 1'b1;
                    state_nxt = SPIN_PULSE;
                    cnt_nxt   = '0;
                    p7_nxt    = 1'b0;
                    p9_nxt    = ~acc[SPIN_W-1];
                end
            end
            SPIN_PULSE: begin
                if (ce_i) begin
                    if (cnt == CNT_LAST) begin
                        state_nxt = SPIN_GAP;
                        cnt_nxt   = '0;
                        p7_nxt    = 1'b1;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
            end
            SPIN_GAP: begin
                if (ce_i) begin
                    if (cnt == CNT_LAST) begin
                        state_nxt = SPIN_IDLE;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
            end
            default: state_nxt = SPIN_IDLE;
        endcase
    end

    // Strobe and step combine before saturation so neither update is lost
    always_comb begin
        delta   = spin_stb_i ? (SPIN_W+2)'(spin_d_i) : '0;
        dec     = '0;
        if (step) dec = acc[SPIN_W-1] ? -ONE : ONE;
        sum     = (SPIN_W+2)'(acc) + delta - dec;
        acc_nxt = sat_acc(sum);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state     <= SPIN_IDLE;
            cnt       <= '0;
            acc       <= '0;
            ctrl_p7_o <= 1'b1;
            ctrl_p9_o <= 1'b1;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            acc       <= acc_nxt;
            ctrl_p7_o <= p7_nxt;
            ctrl_p9_o <= p9_nxt;
        end
    end

endmodule

// File: rtl/cv_pad_port.sv
// ColecoVision controller port emulation: maps MiSTer joystick bitmaps onto
// the active-low keypad/joystick matrix, with autofire and spinner pulses.
module cv_pad_port
    import cv_pad_pkg::*;
#(
    parameter int NPORTS    = 2,
    parameter int SPIN_W    = 8,
    parameter int PULSE_LEN = 4,
    parameter int TURBO_DIV = 6
) (
    input  logic                           clk_i,
    input  logic                           reset_i,
    input  logic                           ce_i,
    input  logic                           swap_i,
    input  logic [NPORTS-1:0][31:0]        joy_i,
    input  logic [NPORTS-1:0][1:0]         turbo_i,
    input  logic [NPORTS-1:0][SPIN_W-1:0]  spin_d_i,
    input  logic [NPORTS-1:0]              spin_stb_i,
    input  logic [NPORTS-1:0]              ctrl_p5_i,
    input  logic [NPORTS-1:0]              ctrl_p8_i,
    output logic [NPORTS-1:0]              ctrl_p1_o,
    output logic [NPORTS-1:0]              ctrl_p2_o,
    output logic [NPORTS-1:0]              ctrl_p3_o,
    output logic [NPORTS-1:0]              ctrl_p4_o,
    output logic [NPORTS-1:0]              ctrl_p6_o,
    output logic [NPORTS-1:0]              ctrl_p7_o,
    output logic [NPORTS-1:0]              ctrl_p9_o
);

    logic [TURBO_DIV-1:0] turbo_cnt;
    logic                 turbo_ph;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            turbo_cnt <= '0;
            turbo_ph  <= 1'b1;
        end else if (ce_i) begin
            turbo_cnt <= turbo_cnt + 1'b1;
            if (&turbo_cnt) turbo_ph <= ~turbo_ph;
        end
    end

    for (genvar p = 0; p < NPORTS; p++) begin : g_port
        // Ports 0 and 1 may trade inputs; other ports always use their own
        localparam int ALT = (p < 2 && NPORTS >= 2) ? 1 - p : p;

        logic [31:0]       joy_s;
        logic [1:0]        turbo_s;
        logic [SPIN_W-1:0] spin_d_s;
        logic              spin_stb_s;
        logic              use_alt;
        logic              fire1, fire2;
        logic [3:0]        key_bits, dir_bits;
        logic              fire_n;
        logic [4:0]        pins_p1;

        assign use_alt    = swap_i & (ALT != p);
        assign joy_s      = use_alt ? joy_i[ALT]      : joy_i[p];
        assign turbo_s    = use_alt ? turbo_i[ALT]    : turbo_i[p];
        assign spin_d_s   = use_alt ? spin_d_i[ALT]   : spin_d_i[p];
        assign spin_stb_s = use_alt ? spin_stb_i[ALT] : spin_stb_i[p];

        always_comb begin
            fire1    = joy_s[JOY_FIRE1] & (~turbo_s[0] | turbo_ph);
            fire2    = joy_s[JOY_FIRE2] & (~turbo_s[1] | turbo_ph);
            key_bits = ctrl_p5_i[p] ? 4'b1111 : key_encode(joy_s);
            dir_bits = ctrl_p8_i[p] ? 4'b1111
                     : ~{joy_s[JOY_U], joy_s[JOY_D], joy_s[JOY_L], joy_s[JOY_R]};
            fire_n   = (ctrl_p5_i[p] | ~fire2) & (ctrl_p8_i[p] | ~fire1);
        end

        // Stage boundary: matrix and fire lines registered as {p1,p2,p3,p4,p6}
        always_ff @(posedge clk_i) begin
            if (reset_i) pins_p1 <= '1;
            else         pins_p1 <= {key_bits & dir_bits, fire_n};
        end

        assign ctrl_p1_o[p] = pins_p1[4];
        assign ctrl_p2_o[p] = pins_p1[3];
        assign ctrl_p3_o[p] = pins_p1[2];
        assign ctrl_p4_o[p] = pins_p1[1];
        assign ctrl_p6_o[p] = pins_p1[0];

        cv_spinner #(
            .SPIN_W    (SPIN_W),
            .PULSE_LEN (PULSE_LEN)
        ) u_spinner (
            .clk_i      (clk_i),
            .reset_i    (reset_i),
            .ce_i       (ce_i),
            .spin_d_i   (spin_d_s),
            .spin_stb_i (spin_stb_s),
            .ctrl_p7_o  (ctrl_p7_o[p]),
            .ctrl_p9_o  (ctrl_p9_o[p])
        );
    end

endmodule

// File: tb/tb_cv_pad_port.sv
// Directed bench for cv_pad_port: keypad/joystick matrix, autofire timing,
// spinner pulse counts and saturation, swap and reset behaviour.
module tb_cv_pad_port;

    localparam int NPORTS    = 2;
    localparam int SPIN_W    = 8;
    localparam int PULSE_LEN = 4;
    localparam int TURBO_DIV = 6;

    logic                          clk_i = 1'b0;
    logic                          reset_i;
    logic                          ce_i;
    logic                          swap_i;
    logic [NPORTS-1:0][31:0]       joy_i;
    logic [NPORTS-1:0][1:0]        turbo_i;
    logic [NPORTS-1:0][SPIN_W-1:0] spin_d_i;
    logic [NPORTS-1:0]             spin_stb_i;
    logic [NPORTS-1:0]             ctrl_p5_i;
    logic [NPORTS-1:0]             ctrl_p8_i;
    logic [NPORTS-1:0]             ctrl_p1_o, ctrl_p2_o, ctrl_p3_o, ctrl_p4_o;
    logic [NPORTS-1:0]             ctrl_p6_o, ctrl_p7_o, ctrl_p9_o;

    int n_cmp = 0;
    int n_bad = 0;

    cv_pad_port #(
        .NPORTS    (NPORTS),
        .SPIN_W    (SPIN_W),
        .PULSE_LEN (PULSE_LEN),
        .TURBO_DIV (TURBO_DIV)
    ) dut (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .ce_i       (ce_i),
        .swap_i     (swap_i),
        .joy_i      (joy_i),
        .turbo_i    (turbo_i),
        .spin_d_i   (spin_d_i),
        .spin_stb_i (spin_stb_i),
        .ctrl_p5_i  (ctrl_p5_i),
        .ctrl_p8_i  (ctrl_p8_i),
        .ctrl_p1_o  (ctrl_p1_o),
        .ctrl_p2_o  (ctrl_p2_o),
        .ctrl_p3_o  (ctrl_p3_o),
        .ctrl_p4_o  (ctrl_p4_o),
        .ctrl_p6_o  (ctrl_p6_o),
        .ctrl_p7_o  (ctrl_p7_o),
        .ctrl_p9_o  (ctrl_p9_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] mat(input int p);
        return {ctrl_p1_o[p], ctrl_p2_o[p], ctrl_p3_o[p], ctrl_p4_o[p]};
    endfunction

    function automatic logic [6:0] pins(input int p);
        return {mat(p), ctrl_p6_o[p], ctrl_p7_o[p], ctrl_p9_o[p]};
    endfunction

    // Spinner pulse monitor: counts p7 falling edges by direction and flags
    // pulses whose low time or preceding high time is off.
    int          falls_pos [NPORTS] = '{default: 0};
    int          falls_neg [NPORTS] = '{default: 0};
    int          bad_w     [NPORTS] = '{default: 0};
    int          low_run   [NPORTS] = '{default: 0};
    int          hi_run    [NPORTS] = '{default: 100};
    logic [NPORTS-1:0] p7_q = '1;

    always @(negedge clk_i) begin
        for (int p = 0; p < NPORTS; p++) begin
            if (p7_q[p] && ctrl_p7_o[p] === 1'b0) begin
                if (ctrl_p9_o[p]) falls_pos[p]++;
                else              falls_neg[p]++;
                if (hi_run[p] < PULSE_LEN) bad_w[p]++;
                low_run[p] = 1;
            end else if (!p7_q[p] && ctrl_p7_o[p] === 1'b1) begin
                if (low_run[p] != PULSE_LEN) bad_w[p]++;
                hi_run[p] = 1;
            end else if (ctrl_p7_o[p] === 1'b0) begin
                low_run[p]++;
            end else begin
                hi_run[p]++;
            end
        end
        p7_q = ctrl_p7_o;
    end

    task automatic strobe(input int p, input logic [SPIN_W-1:0] d);
        spin_d_i[p]   = d;
        spin_stb_i[p] = 1'b1;
        @(negedge clk_i);
        spin_stb_i[p] = 1'b0;
        spin_d_i[p]   = '0;
    endtask

    logic [31:0] key_joy [13] = '{
        32'h0000_2200, 32'h0000_0000, 32'h0008_0000, 32'h000C_0000,
        32'h0000_00C0, 32'h0004_0080, 32'h0002_0040, 32'h0002_0100,
        32'h0001_9000, 32'h0000_4000, 32'h0000_0400, 32'h0000_0800,
        32'h0000_2020
    };
    logic [4:0] key_exp [13] = '{
        5'b1110_1, 5'b1111_1, 5'b0010_1, 5'b0100_1,
        5'b1010_1, 5'b0101_1, 5'b1011_1, 5'b0011_1,
        5'b0001_1, 5'b0111_1, 5'b1101_1, 5'b0110_1,
        5'b1001_0
    };

    int sp0, sn0, sp1, sn1, sb0, k;

    initial begin
        reset_i    = 1'b1;
        ce_i       = 1'b0;
        swap_i     = 1'b0;
        joy_i      = '0;
        turbo_i    = '0;
        spin_d_i   = '0;
        spin_stb_i = '0;
        ctrl_p5_i  = '1;
        ctrl_p8_i  = '1;
        repeat (3) @(negedge clk_i);
        check_val("reset_p0", 32'(pins(0)), 32'h7F);
        check_val("reset_p1", 32'(pins(1)), 32'h7F);
        reset_i = 1'b0;
        @(negedge clk_i);

        // Keypad select: one-cycle latency, then the priority table
        ctrl_p5_i[0] = 1'b0;
        joy_i[0]     = 32'h0000_2200;
        check_val("latency_old", 32'(mat(0)), 32'hF);
        @(negedge clk_i);
        check_val("latency_new", 32'(mat(0)), 32'hE);
        for (int i = 0; i < 13; i++) begin
            joy_i[0] = key_joy[i];
            @(negedge clk_i);
            check_val($sformatf("key_%0d", i), 32'({mat(0), ctrl_p6_o[0]}), 32'(key_exp[i]));
        end
        check_val("idle_port1", 32'({mat(1), ctrl_p6_o[1]}), 32'h1F);

        // Joystick select
        ctrl_p5_i[0] = 1'b1;
        ctrl_p8_i[0] = 1'b0;
        joy_i[0]     = 32'h18;
        @(negedge clk_i);
        check_val("joy_up_fire1", 32'({mat(0), ctrl_p6_o[0]}), 32'b0111_0);
        joy_i[0] = 32'h07;
        @(negedge clk_i);
        check_val("joy_dlr", 32'({mat(0), ctrl_p6_o[0]}), 32'b1000_1);
        joy_i[0] = 32'h20;
        @(negedge clk_i);
        check_val("joy_fire2_desel", 32'({mat(0), ctrl_p6_o[0]}), 32'b1111_1);

        // Both selects low, then both high
        ctrl_p5_i[0] = 1'b0;
        joy_i[0]     = 32'h101;
        @(negedge clk_i);
        check_val("both_key0_r", 32'({mat(0), ctrl_p6_o[0]}), 32'b0010_1);
        joy_i[0] = 32'h30;
        @(negedge clk_i);
        check_val("both_fires", 32'({mat(0), ctrl_p6_o[0]}), 32'b1111_0);
        ctrl_p5_i[0] = 1'b1;
        ctrl_p8_i[0] = 1'b1;
        joy_i[0]     = 32'h000F_FFFF;
        @(negedge clk_i);
        check_val("none_sel", 32'({mat(0), ctrl_p6_o[0]}), 32'b1111_1);

        // Swap of joystick inputs
        ctrl_p8_i = '0;
        joy_i[0]  = 32'h08;
        joy_i[1]  = 32'h04;
        swap_i    = 1'b1;
        @(negedge clk_i);
        check_val("swap_p0", 32'(mat(0)), 32'b1011);
        check_val("swap_p1", 32'(mat(1)), 32'b0111);
        swap_i = 1'b0;
        @(negedge clk_i);
        check_val("noswap_p0", 32'(mat(0)), 32'b0111);
        check_val("noswap_p1", 32'(mat(1)), 32'b1011);
        ctrl_p8_i = '1;
        joy_i     = '0;

        // Autofire: phase starts at 1, first toggle after 64 ticks
        ctrl_p8_i[0] = 1'b0;
        joy_i[0]     = 32'h10;
        turbo_i[0]   = 2'b01;
        @(negedge clk_i);
        check_val("turbo_start", 32'(ctrl_p6_o[0]), 32'h0);
        ce_i = 1'b1;
        k    = 0;
        while (k < 200 && ctrl_p6_o[0] !== 1'b1) begin
            @(negedge clk_i);
            k++;
        end
        check_val("turbo_first", 32'(k), 32'd65);
        k = 0;
        while (k < 200 && ctrl_p6_o[0] !== 1'b0) begin
            @(negedge clk_i);
            k++;
        end
        check_val("turbo_period", 32'(k), 32'd64);
        turbo_i[0] = 2'b00;
        @(negedge clk_i);
        @(negedge clk_i);
        check_val("turbo_off", 32'(ctrl_p6_o[0]), 32'h0);
        ctrl_p8_i = '1;
        joy_i     = '0;

        // Spinner +3
        sp0 = falls_pos[0]; sn0 = falls_neg[0]; sb0 = bad_w[0];
        strobe(0, 8'd3);
        repeat (45) @(negedge clk_i);
        check_val("spin3_pos", 32'(falls_pos[0] - sp0), 32'd3);
        check_val("spin3_neg", 32'(falls_neg[0] - sn0), 32'd0);
        check_val("spin3_width", 32'(bad_w[0] - sb0), 32'd0);
        check_val("spin3_idle", 32'({ctrl_p7_o[0], ctrl_p9_o[0]}), 32'b11);

        // Saturation: 126, then +5 coinciding with the first step -> 127
        sp0 = falls_pos[0]; sn0 = falls_neg[0]; sb0 = bad_w[0];
        strobe(0, 8'd126);
        strobe(0, 8'd5);
        repeat (300) @(negedge clk_i);
        strobe(0, 8'hFE);
        repeat (1100) @(negedge clk_i);
        check_val("sat_pos", 32'(falls_pos[0] - sp0), 32'd126);
        check_val("sat_neg", 32'(falls_neg[0] - sn0), 32'd0);
        check_val("sat_width", 32'(bad_w[0] - sb0), 32'd0);
        check_val("sat_p9_hold", 32'(ctrl_p9_o[0]), 32'h1);
        sn0 = falls_neg[0];
        strobe(0, 8'hFE);
        repeat (30) @(negedge clk_i);
        check_val("flip_neg", 32'(falls_neg[0] - sn0), 32'd2);
        check_val("flip_p9", 32'(ctrl_p9_o[0]), 32'h0);

        // Negative saturation on port 1: -128 clamps to -127
        sp1 = falls_pos[1]; sn1 = falls_neg[1];
        strobe(1, 8'h80);
        repeat (1200) @(negedge clk_i);
        check_val("negsat_neg", 32'(falls_neg[1] - sn1), 32'd127);
        check_val("negsat_pos", 32'(falls_pos[1] - sp1), 32'd0);
        check_val("negsat_p9", 32'(ctrl_p9_o[1]), 32'h0);

        // Swapped spinner input lands on port 1
        sp0 = falls_pos[0]; sp1 = falls_pos[1];
        swap_i = 1'b1;
        @(negedge clk_i);
        strobe(0, 8'd2);
        swap_i = 1'b0;
        repeat (30) @(negedge clk_i);
        check_val("swapspin_p1", 32'(falls_pos[1] - sp1), 32'd2);
        check_val("swapspin_p0", 32'(falls_pos[0] - sp0), 32'd0);

        // Reset in the middle of a pulse, with a strobe that must be dropped
        strobe(0, 8'd3);
        k = 0;
        while (k < 20 && ctrl_p7_o[0] !== 1'b0) begin
            @(negedge clk_i);
            k++;
        end
        check_val("pulse_seen", 32'(ctrl_p7_o[0]), 32'h0);
        reset_i       = 1'b1;
        spin_d_i[0]   = 8'd5;
        spin_stb_i[0] = 1'b1;
        @(negedge clk_i);
        check_val("midreset_p0", 32'(pins(0)), 32'h7F);
        check_val("midreset_p1", 32'(pins(1)), 32'h7F);
        reset_i       = 1'b0;
        spin_stb_i[0] = 1'b0;
        spin_d_i[0]   = '0;
        sp0 = falls_pos[0]; sn0 = falls_neg[0];
        repeat (60) @(negedge clk_i);
        check_val("postreset_pulses", 32'((falls_pos[0] - sp0) + (falls_neg[0] - sn0)), 32'd0);
        check_val("postreset_p7", 32'(ctrl_p7_o[0]), 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
